aud_session_ctrl: RTL and testbench
===================================

Name: aud_session_ctrl

Overview:
Parametrised session controller for the audio datapath: codec-init handshake, then RECORD / PLAY / SYNTH sessions across NUM_CH DSP channels.
- Adds pause/resume, stop, an elapsed-seconds timer with auto-stop, and an I2C-init timeout with error recovery.
- Sits between the debounced key inputs and the I2C initializer, recorder, DSP channels and player enables.
- All outputs are registered.

Parameters:
NUM_CH, 2, number of DSP channels with individual start pulses (1..8)
CLK_HZ, 12000000, i_clk cycles per elapsed second
TIME_W, 6, width of o_time
MAX_SEC, 32, session length in seconds before auto-stop (2..2^TIME_W-1)
I2C_TIMEOUT, 2000000, i_clk cycles allowed for codec init before error

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  async active-low reset
i_i2c_fin  in  1  I2C initializer finished (level, synchronous to i_clk)
i_key_start  in  1  start/resume, one-cycle pulse
i_key_pause  in  1  pause toggle, one-cycle pulse
i_key_stop  in  1  stop / error clear, one-cycle pulse
i_mode  in  2  0=PLAY, 1=RECORD, 2=SYNTH, 3=reserved
i_ch_en  in  NUM_CH  channel enable mask sampled at start
o_i2c_start  out  1  one-cycle init request
o_rec_start  out  1  one-cycle recorder start pulse
o_dsp_start  out  NUM_CH  one-cycle per-channel DSP start pulses
o_play_en  out  1  player enable
o_rec_en  out  1  recorder enable
o_pause  out  1  high in PAUSE
o_time  out  TIME_W  elapsed seconds of current session
o_err  out  1  high in ERR
o_state  out  3  current state code

Behaviour:
- Reset clears all outputs to 0 except o_state. State resets to I2C.
- State codes: IDLE=0, I2C=1, RUN=2, PAUSE=3, DONE=4, ERR=5.
- Every transition takes effect on the clock edge after the triggering input; outputs reflect the new state that same edge.
- Key priority when pulses coincide: stop > pause > start.

I2C:
- o_i2c_start is high for exactly one cycle, on the first edge after reset release and on every re-entry to I2C.
- A timeout counter runs. i_i2c_fin=1 goes to IDLE. The counter reaching I2C_TIMEOUT-1 without fin goes to ERR.
- Keys are ignored in I2C.

ERR:
- o_err=1.
- i_key_stop goes to I2C (fresh o_i2c_start pulse, counter cleared). Other keys are ignored.

IDLE:
- i_key_start with i_mode!=3 and i_ch_en!=0 latches mode and mask, clears o_time and the prescaler, and goes to RUN.
- Otherwise the start is ignored and the state stays IDLE.

RUN entry edge:
- o_dsp_start = latched mask for one cycle.
- o_rec_start = 1 for one cycle if mode is RECORD.

RUN:
- o_play_en=1 for PLAY/SYNTH; o_rec_en=1 for RECORD.
- The prescaler counts 0..CLK_HZ-1; on wrap o_time increments.
- A tick while o_time==MAX_SEC-1 sets o_time=MAX_SEC and goes to DONE.
- i_key_pause goes to PAUSE. i_key_stop goes to IDLE with o_time cleared.
- i_mode and i_ch_en changes are ignored (latched values are used).

PAUSE:
- o_pause=1, enables low, prescaler and o_time frozen.
- i_key_pause or i_key_start resumes RUN with no start pulses and the prescaler continuing.
- i_key_stop goes to IDLE with o_time cleared.

DONE:
- Enables low, o_time held at MAX_SEC.
- i_key_start or i_key_stop goes to IDLE with o_time cleared.

Asynchronous reset mid-session: immediate return to I2C with all outputs 0. The single o_i2c_start pulse is issued after release.

Counter widths:
- Prescaler is ceil(log2(CLK_HZ)) bits.
- Timeout counter is ceil(log2(I2C_TIMEOUT)) bits.
- Neither counter may overflow.

Test Plan:
1. Bench settings CLK_HZ=10, MAX_SEC=4, I2C_TIMEOUT=50, NUM_CH=2. Release reset, assert i_i2c_fin at cycle 5 -> o_i2c_start high only on cycle 1; o_state=0 from cycle 6.
2. Hold i_i2c_fin=0 -> o_state=5 and o_err=1 after 50 cycles. Pulse stop -> o_state=1 with a new o_i2c_start pulse. Fin -> IDLE.
3. IDLE, mode=1, ch_en=2'b10, start -> next edge o_state=2, o_dsp_start=2'b10 and o_rec_start=1 for one cycle, o_rec_en=1. After 40 cycles o_time=4 and o_state=4, o_rec_en=0.
4. PLAY session: pause at 15 cycles -> o_time=1, frozen for 100 cycles, o_play_en=0. Resume -> no start pulses, o_time=2 after 5 more cycles.
5. Start with ch_en=0 or mode=3 -> stays IDLE, no pulses. Stop+pause+start in the same cycle during RUN -> IDLE, o_time=0.
6. Reset asserted mid-RUN -> all outputs 0 immediately; one o_i2c_start pulse after release.

Source files
------------

// File: rtl/aud_session_ctrl.sv
// aud_session_ctrl
//   Session controller for the audio datapath. After reset it requests a
//   codec init over I2C, then runs RECORD / PLAY / SYNTH sessions across
//   NUM_CH DSP channels with pause/resume, stop, an elapsed-seconds timer
//   with auto-stop at MAX_SEC, and an I2C-init timeout into an error state
//   that the stop key clears.
//
// Ports
//   i_clk, i_rst_n   system clock, async active-low reset
//   i_i2c_fin        I2C initializer finished (level)
//   i_key_start      start / resume pulse
//   i_key_pause      pause toggle pulse
//   i_key_stop       stop / error-clear pulse
//   i_mode           0=PLAY 1=RECORD 2=SYNTH 3=reserved
//   i_ch_en          channel enable mask, sampled at session start
//   o_i2c_start      one-cycle codec init request
//   o_rec_start      one-cycle recorder start
//   o_dsp_start      one-cycle per-channel DSP start
//   o_play_en        player enable
//   o_rec_en         recorder enable
//   o_pause          high while paused
//   o_time           elapsed seconds of current session
//   o_err            high in the error state
//   o_state          current state code
module aud_session_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int CLK_HZ      = 12000000,
  parameter int TIME_W      = 6,
  parameter int MAX_SEC     = 32,
  parameter int I2C_TIMEOUT = 2000000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_i2c_fin,
  input  logic              i_key_start,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [1:0]        i_mode,
  input  logic [NUM_CH-1:0] i_ch_en,
  output logic              o_i2c_start,
  output logic              o_rec_start,
  output logic [NUM_CH-1:0] o_dsp_start,
  output logic              o_play_en,
  output logic              o_rec_en,
  output logic              o_pause,
  output logic [TIME_W-1:0] o_time,
  output logic              o_err,
  output logic [2:0]        o_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_I2C   = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_PAUSE = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  localparam logic [1:0] MODE_REC = 2'd1;
  localparam logic [1:0] MODE_RSV = 2'd3;

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int TO_W  = (I2C_TIMEOUT > 1) ? $clog2(I2C_TIMEOUT) : 1;

  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(CLK_HZ - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(I2C_TIMEOUT - 1);
  localparam logic [TIME_W-1:0] SEC_LAST = TIME_W'(MAX_SEC - 1);
  localparam logic [TIME_W-1:0] SEC_END  = TIME_W'(MAX_SEC);

  logic [2:0]        state_q,     state_d;
  logic              boot_q,      boot_d;
  logic [TO_W-1:0]   to_cnt_q,    to_cnt_d;
  logic [PRE_W-1:0]  pre_q,       pre_d;
  logic [TIME_W-1:0] time_q,      time_d;
  logic [1:0]        mode_q,      mode_d;
  logic [NUM_CH-1:0] mask_q,      mask_d;
  logic              i2c_start_q, i2c_start_d;
  logic              rec_start_q, rec_start_d;
  logic [NUM_CH-1:0] dsp_start_q, dsp_start_d;
  logic              play_en_q,   play_en_d;
  logic              rec_en_q,    rec_en_d;
  logic              pause_q,     pause_d;
  logic              err_q,       err_d;

  always_comb begin
    state_d     = state_q;
    boot_d      = 1'b0;
    to_cnt_d    = to_cnt_q;
    pre_d       = pre_q;
    time_d      = time_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    // boot_q is only set out of reset, so this yields the single init
    // request on the first edge after release.
    i2c_start_d = boot_q;
    rec_start_d = 1'b0;
    dsp_start_d = '0;

    case (state_q)
      ST_I2C: begin
        if (i_i2c_fin) begin
          state_d  = ST_IDLE;
          to_cnt_d = '0;
        end else if (to_cnt_q == TO_LAST) begin
          state_d  = ST_ERR;
          to_cnt_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_ERR: begin
        if (i_key_stop) begin
          state_d     = ST_I2C;
          to_cnt_d    = '0;
          i2c_start_d = 1'b1;
        end
      end
      ST_IDLE: begin
        // A coincident stop or pause outranks start, so start is dropped.
        if (i_key_start && !i_key_stop && !i_key_pause &&
            (i_mode != MODE_RSV) && (|i_ch_en)) begin
          state_d     = ST_RUN;
          mode_d      = i_mode;
          mask_d      = i_ch_en;
          time_d      = '0;
          pre_d       = '0;
          dsp_start_d = i_ch_en;
          rec_start_d = (i_mode == MODE_REC);
        end
      end
      ST_RUN: begin
        if (i_key_stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (i_key_pause) begin
          // Prescaler is not advanced on the pausing edge so the partial
          // second resumes exactly where it left off.
          state_d = ST_PAUSE;
        end else if (pre_q == PRE_LAST) begin
          pre_d = '0;
          if (time_q == SEC_LAST) begin
            time_d  = SEC_END;
            state_d = ST_DONE;
          end else begin
            time_d = time_q + TIME_W'(1);
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      ST_PAUSE: begin
        if (i_key_stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end else if (i_key_pause || i_key_start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (i_key_start || i_key_stop) begin
          state_d = ST_IDLE;
          time_d  = '0;
        end
      end
      default: begin
        // Unused codes recover through a fresh codec init.
        state_d     = ST_I2C;
        to_cnt_d    = '0;
        i2c_start_d = 1'b1;
      end
    endcase

    // Level outputs are decoded from the next state so they change on the
    // same edge as the state itself.
    play_en_d = (state_d == ST_RUN) && (mode_d != MODE_REC);
    rec_en_d  = (state_d == ST_RUN) && (mode_d == MODE_REC);
    pause_d   = (state_d == ST_PAUSE);
    err_d     = (state_d == ST_ERR);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_I2C;
      boot_q      <= 1'b1;
      to_cnt_q    <= '0;
      pre_q       <= '0;
      time_q      <= '0;
      mode_q      <= '0;
      mask_q      <= '0;
      i2c_start_q <= 1'b0;
      rec_start_q <= 1'b0;
      dsp_start_q <= '0;
      play_en_q   <= 1'b0;
      rec_en_q    <= 1'b0;
      pause_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      boot_q      <= boot_d;
      to_cnt_q    <= to_cnt_d;
      pre_q       <= pre_d;
      time_q      <= time_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      i2c_start_q <= i2c_start_d;
      rec_start_q <= rec_start_d;
      dsp_start_q <= dsp_start_d;
      play_en_q   <= play_en_d;
      rec_en_q    <= rec_en_d;
      pause_q     <= pause_d;
      err_q       <= err_d;
    end
  end

  assign o_i2c_start = i2c_start_q;
  assign o_rec_start = rec_start_q;
  assign o_dsp_start = dsp_start_q;
  assign o_play_en   = play_en_q;
  assign o_rec_en    = rec_en_q;
  assign o_pause     = pause_q;
  assign o_time      = time_q;
  assign o_err       = err_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// tb_aud_session_ctrl
//   Directed-vector bench for aud_session_ctrl with short timing parameters
//   (CLK_HZ=10, MAX_SEC=4, I2C_TIMEOUT=50, NUM_CH=2). Expected values are
//   hand-derived cycle counts from the controller behaviour.
module tb_aud_session_ctrl;

  localparam int NUM_CH      = 2;
  localparam int CLK_HZ      = 10;
  localparam int TIME_W      = 6;
  localparam int MAX_SEC     = 4;
  localparam int I2C_TIMEOUT = 50;

  logic              clk;
  logic              rst_n;
  logic              i2c_fin;
  logic              key_start;
  logic              key_pause;
  logic              key_stop;
  logic [1:0]        mode;
  logic [NUM_CH-1:0] ch_en;
  logic              i2c_start;
  logic              rec_start;
  logic [NUM_CH-1:0] dsp_start;
  logic              play_en;
  logic              rec_en;
  logic              pause;
  logic [TIME_W-1:0] time_s;
  logic              err;
  logic [2:0]        state;

  int n_vec;
  int n_miss;

  aud_session_ctrl #(
    .NUM_CH      (NUM_CH),
    .CLK_HZ      (CLK_HZ),
    .TIME_W      (TIME_W),
    .MAX_SEC     (MAX_SEC),
    .I2C_TIMEOUT (I2C_TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_i2c_fin   (i2c_fin),
    .i_key_start (key_start),
    .i_key_pause (key_pause),
    .i_key_stop  (key_stop),
    .i_mode      (mode),
    .i_ch_en     (ch_en),
    .o_i2c_start (i2c_start),
    .o_rec_start (rec_start),
    .o_dsp_start (dsp_start),
    .o_play_en   (play_en),
    .o_rec_en    (rec_en),
    .o_pause     (pause),
    .o_time      (time_s),
    .o_err       (err),
    .o_state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clock edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".i2c_start"}, i2c_start, 0);
    chk({tag, ".rec_start"}, rec_start, 0);
    chk({tag, ".dsp_start"}, dsp_start, 0);
    chk({tag, ".play_en"},   play_en,   0);
    chk({tag, ".rec_en"},    rec_en,    0);
    chk({tag, ".pause"},     pause,     0);
    chk({tag, ".time"},      time_s,    0);
    chk({tag, ".err"},       err,       0);
  endtask

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    i2c_fin   = 1'b0;
    key_start = 1'b0;
    key_pause = 1'b0;
    key_stop  = 1'b0;
    mode      = 2'd0;
    ch_en     = '0;

    // 1: reset state, single init pulse, fin at cycle 5 -> IDLE at cycle 6
    tick(2);
    chk("rst.state", state, 1);
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick(1);
    chk("c1.i2c_start", i2c_start, 1);
    chk("c1.state", state, 1);
    tick(1);
    chk("c2.i2c_start", i2c_start, 0);
    tick(2);
    chk("c4.i2c_start", i2c_start, 0);
    tick(1);
    i2c_fin = 1'b1;
    chk("c5.state", state, 1);
    tick(1);
    chk("c6.state", state, 0);
    chk("c6.i2c_start", i2c_start, 0);

    // 2: init timeout into ERR, stop recovers with a fresh init
    rst_n   = 1'b0;
    i2c_fin = 1'b0;
    tick(1);
    rst_n = 1'b1;
    tick(49);
    chk("to49.state", state, 1);
    chk("to49.err", err, 0);
    tick(1);
    chk("to50.state", state, 5);
    chk("to50.err", err, 1);
    key_start = 1'b1;
    key_pause = 1'b1;
    tick(1);
    key_start = 1'b0;
    key_pause = 1'b0;
    chk("err_keys.state", state, 5);
    key_stop = 1'b1;
    tick(1);
    key_stop = 1'b0;
    chk("clr.state", state, 1);
    chk("clr.i2c_start", i2c_start, 1);
    chk("clr.err", err, 0);
    tick(1);
    chk("clr1.i2c_start", i2c_start, 0);
    // counter restarted at the stop edge: 49 more edges still in I2C
    tick(48);
    chk("clr49.state", state, 1);
    i2c_fin = 1'b1;
    tick(1);
    chk("fin.state", state, 0);

    // 3: RECORD session on channel 1, auto-stop after MAX_SEC seconds
    mode      = 2'd1;
    ch_en     = 2'b10;
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    mode      = 2'd0;
    ch_en     = 2'b00;
    chk("rec.state", state, 2);
    chk("rec.dsp_start", dsp_start, 2'b10);
    chk("rec.rec_start", rec_start, 1);
    chk("rec.rec_en", rec_en, 1);
    chk("rec.play_en", play_en, 0);
    tick(1);
    chk("rec1.dsp_start", dsp_start, 0);
    chk("rec1.rec_start", rec_start, 0);
    chk("rec1.rec_en", rec_en, 1);
    tick(38);
    chk("rec39.time", time_s, 3);
    chk("rec39.state", state, 2);
    tick(1);
    chk("rec40.time", time_s, 4);
    chk("rec40.state", state, 4);
    chk("rec40.rec_en", rec_en, 0);
    tick(5);
    chk("done.time", time_s, 4);
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("done_start.state", state, 0);
    chk("done_start.time", time_s, 0);

    // 4: PLAY session with pause and resume
    mode      = 2'd0;
    ch_en     = 2'b11;
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("play.state", state, 2);
    chk("play.dsp_start", dsp_start, 2'b11);
    chk("play.rec_start", rec_start, 0);
    chk("play.play_en", play_en, 1);
    tick(15);
    chk("play15.time", time_s, 1);
    key_pause = 1'b1;
    tick(1);
    key_pause = 1'b0;
    chk("pause.state", state, 3);
    chk("pause.pause", pause, 1);
    chk("pause.play_en", play_en, 0);
    tick(100);
    chk("pause100.time", time_s, 1);
    chk("pause100.state", state, 3);
    key_pause = 1'b1;
    tick(1);
    key_pause = 1'b0;
    chk("resume.state", state, 2);
    chk("resume.dsp_start", dsp_start, 0);
    chk("resume.rec_start", rec_start, 0);
    chk("resume.pause", pause, 0);
    chk("resume.play_en", play_en, 1);
    tick(4);
    chk("resume4.time", time_s, 1);
    tick(1);
    chk("resume5.time", time_s, 2);

    // 5: coincident keys during RUN, then rejected starts in IDLE
    key_stop  = 1'b1;
    key_pause = 1'b1;
    key_start = 1'b1;
    tick(1);
    key_stop  = 1'b0;
    key_pause = 1'b0;
    key_start = 1'b0;
    chk("all_keys.state", state, 0);
    chk("all_keys.time", time_s, 0);
    chk("all_keys.play_en", play_en, 0);
    mode      = 2'd3;
    ch_en     = 2'b11;
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("rsv.state", state, 0);
    chk("rsv.dsp_start", dsp_start, 0);
    chk("rsv.rec_start", rec_start, 0);
    mode      = 2'd1;
    ch_en     = 2'b00;
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("nomask.state", state, 0);
    chk("nomask.dsp_start", dsp_start, 0);
    chk("nomask.rec_start", rec_start, 0);

    // 6: async reset in the middle of a SYNTH session
    mode      = 2'd2;
    ch_en     = 2'b01;
    key_start = 1'b1;
    tick(1);
    key_start = 1'b0;
    chk("synth.state", state, 2);
    chk("synth.dsp_start", dsp_start, 2'b01);
    chk("synth.play_en", play_en, 1);
    tick(12);
    chk("synth12.time", time_s, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.state", state, 1);
    chk_all_zero("arst");
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk("rel1.i2c_start", i2c_start, 1);
    tick(1);
    chk("rel2.i2c_start", i2c_start, 0);
    chk("rel2.state", state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
